// File: rtl/pio_handshake_endpoint.sv
// pio_handshake_endpoint
// Fabric-side endpoint of the SoC PIO mailbox. Software posts a 2-bit command
// (00 idle, 01 write, 10 read, 11 reserved) together with an index and a data
// word. A write forwards (index, data) to the fabric write channel. A read
// issues a fabric read request and returns the response word. Status and data
// go back to software through a four-phase handshake, one transaction at a time.
//
// Ports
//   clk_clk, reset_reset_n : system clock, asynchronous active-low reset
//   cmd_sig/cmd_data/cmd_index : command, write data, index from software
//   rsp_sig/rsp_data/rsp_index : status (00 ready, 01 write ack, 10 read valid,
//                                11 error), read data, latched index echo
//   wr_valid/wr_ready/wr_addr/wr_data : fabric write channel
//   rd_valid/rd_ready/rd_addr         : fabric read-request channel
//   rsp_valid/rsp_rdata               : fabric read response (1-cycle strobe)
//   busy                              : high whenever not idle
module pio_handshake_endpoint #(
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [1:0]        cmd_sig,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_index,
  output logic [1:0]        rsp_sig,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_index,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_PUSH = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Command synchronizer: a shift chain, newest sample in the low bits.
  logic [2*SYNC_STAGES-1:0] sync_reg;
  logic [1:0]               cmd_s;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        rsp_sig_reg, rsp_sig_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic [DATA_W-1:0] rsp_index_reg, rsp_index_next;
  logic              wr_valid_reg, wr_valid_next;
  logic [DATA_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              rd_valid_reg, rd_valid_next;
  logic [DATA_W-1:0] rd_addr_reg, rd_addr_next;
  logic              timeout_hit;

  assign cmd_s = sync_reg[2*SYNC_STAGES-1 -: 2];

  // A zero TIMEOUT_CYCLES means the read wait never gives up.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[2*SYNC_STAGES-3:0], cmd_sig};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rsp_sig_reg   <= 2'b00;
      rsp_data_reg  <= '0;
      rsp_index_reg <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_sig_reg   <= rsp_sig_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_index_reg <= rsp_index_next;
      wr_valid_reg  <= wr_valid_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      rd_valid_reg  <= rd_valid_next;
      rd_addr_reg   <= rd_addr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        unique case (cmd_s)
          2'b01:   state_next = S_WR_PUSH;
          2'b10:   state_next = S_RD_REQ;
          2'b11:   state_next = S_HOLD;
          default: state_next = S_IDLE;
        endcase
      end
      S_WR_PUSH: if (wr_valid_reg && wr_ready) state_next = S_HOLD;
      // A response arriving together with the request handshake completes the read.
      S_RD_REQ:  if (rd_valid_reg && rd_ready) state_next = rsp_valid ? S_HOLD : S_RD_WAIT;
      S_RD_WAIT: if (rsp_valid || timeout_hit) state_next = S_HOLD;
      S_HOLD:    if (cmd_s == 2'b00) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    cnt_next       = cnt_reg;
    rsp_sig_next   = rsp_sig_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_index_next = rsp_index_reg;
    wr_valid_next  = wr_valid_reg;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    rd_valid_next  = rd_valid_reg;
    rd_addr_next   = rd_addr_reg;
    unique case (state_reg)
      S_IDLE: begin
        rsp_sig_next = 2'b00;
        unique case (cmd_s)
          2'b01: begin
            wr_addr_next   = cmd_index;
            wr_data_next   = cmd_data;
            rsp_index_next = cmd_index;
            wr_valid_next  = 1'b1;
          end
          2'b10: begin
            rd_addr_next   = cmd_index;
            rsp_index_next = cmd_index;
            rd_valid_next  = 1'b1;
          end
          2'b11:   rsp_sig_next = 2'b11;
          default: ;
        endcase
      end
      S_WR_PUSH: begin
        if (wr_valid_reg && wr_ready) begin
          wr_valid_next = 1'b0;
          rsp_sig_next  = 2'b01;
        end
      end
      S_RD_REQ: begin
        if (rd_valid_reg && rd_ready) begin
          rd_valid_next = 1'b0;
          cnt_next      = '0;
          if (rsp_valid) begin
            rsp_data_next = rsp_rdata;
            rsp_sig_next  = 2'b10;
          end
        end
      end
      S_RD_WAIT: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        // A response on the final cycle beats the timeout.
        if (rsp_valid) begin
          rsp_data_next = rsp_rdata;
          rsp_sig_next  = 2'b10;
        end else if (timeout_hit) begin
          rsp_sig_next = 2'b11;
        end
      end
      S_HOLD: begin
        if (cmd_s == 2'b00) rsp_sig_next = 2'b00;
      end
      default: ;
    endcase
  end

  assign rsp_sig   = rsp_sig_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_index = rsp_index_reg;
  assign wr_valid  = wr_valid_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_addr   = rd_addr_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule
